// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch-side PC controller. Owns the program counter, runs the
// req/ack handshake to instruction memory, and selects branch, jump and
// register-jump targets. It also produces the IF/ID write and flush strobes.
// Optional feature macro: DELAY_SLOT_EN. When it is defined, the instruction
// in IF at redirect time is kept as a delay slot and if_flush is never raised.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch,
  input  logic        jump,
  input  logic        jump_r,
  input  logic [31:0] id_pc_plus4,
  input  logic [15:0] imm16,
  input  logic [25:0] jidx,
  input  logic [31:0] rs_val,
  input  logic        imem_ack,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic        if_valid,
  output logic        if_flush
);

`ifdef DELAY_SLOT_EN
  localparam logic KEEP_SLOT = 1'b1;
`else
  localparam logic KEEP_SLOT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, FETCH, REDIR} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] target;
  logic [31:0] br_off;
  logic [31:0] redir_pc;
  logic        accept;

  assign br_off = {{14{imm16[15]}}, imm16, 2'b00};
  assign pc     = pc_q;

  // Redirect target select: jr beats j beats conditional branch.
  always_comb begin
    target = id_pc_plus4 + br_off;
    if (jump_r)    target = rs_val;
    else if (jump) target = {id_pc_plus4[31:28], jidx, 2'b00};
  end

  // A redirect is taken only when not stalled; a stalled branch may see stale operands.
  assign accept = branch && !stall && (state_q != IDLE);

  // The latest accepted redirect wins over one already pending.
  assign redir_pc = accept ? target : pend_q;

  // Next-state, PC update and fetch-side strobes.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pend_d   = pend_q;
    imem_req = 1'b0;
    if_valid = 1'b0;
    if_flush = 1'b0;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        imem_req = !stall;
        if (accept) begin
          if_flush = !KEEP_SLOT;
          if (imem_ack) begin
            pc_d     = target;
            if_valid = KEEP_SLOT;
          end else begin
            pend_d  = target;
            state_d = REDIR;
          end
        end else if (imem_ack && !stall) begin
          pc_d     = pc_q + 32'd4;
          if_valid = 1'b1;
        end
      end
      REDIR: begin
        imem_req = !stall;
        if (accept) begin
          pend_d   = target;
          if_flush = !KEEP_SLOT;
        end
        if (imem_ack && !stall) begin
          pc_d     = redir_pc;
          state_d  = FETCH;
          if_valid = KEEP_SLOT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, PC and pending-target registers; reset drops any pending redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Fetch-side PC controller: the consumer of the ID-stage branch decision (Branch/Jump/JumpR). It owns the program counter, drives a request/acknowledge handshake to instruction memory, computes branch, jump and register-jump targets, and generates the IF/ID write and flush controls. It sits between the hazard unit, the branch unit and instruction memory at the front of the 5-stage pipeline.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hazard-unit freeze of PC and IF/ID
- branch  in  1  redirect decision from branch unit (ID stage)
- jump  in  1  absolute jump (j); meaningful only with branch=1
- jump_r  in  1  register jump (jr); meaningful only with branch=1
- id_pc_plus4  in  32  PC+4 of the instruction in ID
- imm16  in  16  branch offset field
- jidx  in  26  jump index field
- rs_val  in  32  forwarded rs value (jr target)
- imem_ack  in  1  instruction for pc is returned this cycle; asserted only in a cycle with imem_req=1
- pc  out  32  fetch address; stable while imem_req=1 and no ack
- imem_req  out  1  fetch request
- if_valid  out  1  write fetched instruction into IF/ID this cycle
- if_flush  out  1  clear IF/ID to bubble this cycle

## Operation
- Target select (combinational), priority: jump_r → rs_val; else jump → {id_pc_plus4[31:28], jidx, 2'b00}; else → id_pc_plus4 + (sign_ext(imm16) << 2), 32-bit wrap.
- Redirect accepted only when branch=1 and stall=0; branch during stall ignored (operands may be stale).
- States: IDLE, FETCH, REDIR.
  - IDLE: after reset; imem_req=0; unconditionally → FETCH next cycle.
  - FETCH: imem_req=!stall. On ack with no accepted redirect: pc←pc+4, if_valid=1. On accepted redirect with ack: pc←target (delivered-instruction handling per Configuration). On accepted redirect without ack: target latched into pend_pc, → REDIR; pc unchanged.
  - REDIR: imem_req=!stall, pc held. On ack: pc←pend_pc, → FETCH. New accepted redirect in REDIR overwrites pend_pc (latest wins).
- pc+4 wraps at 2^32 without error.
- stall=1: imem_req=0, pc, state and pend_pc held, if_valid=0; if_flush still generated for a redirect accepted the same cycle is impossible (accept requires stall=0).

## Timing
- Reset values: pc=RESET_PC, imem_req=0, if_valid=0, if_flush=0, state=IDLE, pend_pc=0. rst mid-operation discards any pending redirect immediately (async).
- First request: cycle after rst deasserts is IDLE; imem_req=1 from the following cycle.
- if_valid and if_flush are combinational, same cycle as imem_ack / accepted redirect; pc updates at the next edge.
- Single-cycle memory (ack every request): one instruction per cycle; taken redirect costs one bubble without delay slots, zero with.

## Configuration
- DELAY_SLOT_EN defined: instruction in IF at redirect is the delay slot and is kept — ack in redirect cycle gives if_valid=1; in REDIR the acked instruction gives if_valid=1; if_flush is tied 0.
- Undefined: accepted redirect asserts if_flush=1 that cycle; ack in redirect cycle gives if_valid=0; ack in REDIR gives if_valid=0 (wrong-path instruction discarded).

## Test plan
- Reset, RESET_PC=0x100, imem_ack=1 every request → imem_req rises 2nd cycle after rst release; pc 0x100,0x104,0x108 with if_valid=1 each cycle.
- beq taken at id_pc_plus4=0x208, imm16=0xFFFE, ack same cycle → next pc=0x200; without DELAY_SLOT_EN if_flush=1, if_valid=0; with it if_valid=1, if_flush=0.
- j with id_pc_plus4=0x3000_0010, jidx=0x0000040 → pc=0x3000_0100; jr with rs_val=0x0040_0020 and jump=1 also set → pc=0x0040_0020 (jump_r wins).
- Redirect while imem_ack=0 for 3 cycles → pc held, state REDIR; on ack pc←target, acked instruction valid only if DELAY_SLOT_EN.
- branch=1 with stall=1 → ignored: pc, if_flush unchanged, imem_req=0; jump=1 with branch=0 → no redirect.
- rst asserted while in REDIR → pc=RESET_PC, pending target lost, no redirect after release; pc=0xFFFF_FFFC with ack → wraps to 0x0000_0000.
